// File: rtl/vcnt_gen.sv
// Configurable up/down counter with wrap or saturate behaviour, clamped load,
// Gray-coded mirror of the count and zero/terminal-count flags.
module vcnt_gen #(
    parameter int              WIDTH       = 8,
    parameter longint unsigned MAX         = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP        = 1,
    parameter bit              WRAP        = 1'b1,
    parameter longint unsigned RESET_VALUE = 0,
    parameter longint unsigned SET_VALUE   = MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cke,
    input  logic             clear,
    input  logic             set,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             rew,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next,
    output logic [WIDTH-1:0] q_gray,
    output logic             z,
    output logic             zq,
    output logic             tc
);

    localparam int XW = WIDTH + 1;

    // One extra bit so MAX+1 and q+STEP are always representable.
    localparam logic [XW-1:0]    MAX_X    = XW'(MAX);
    localparam logic [XW-1:0]    STEP_X   = XW'(STEP);
    localparam logic [XW-1:0]    MAXP1_X  = MAX_X + XW'(1);
    localparam logic [XW-1:0]    LIM_UP_X = MAX_X - STEP_X;
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_V    = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] SET_V    = WIDTH'(SET_VALUE);
    localparam logic [WIDTH-1:0] RST_G    = RST_V ^ (RST_V >> 1);

    logic [XW-1:0]    q_x;
    logic [XW-1:0]    sum_x;
    logic [XW-1:0]    diff_x;
    logic             up_over;
    logic             dn_under;
    logic             counting;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_val;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] gray_next;

    always_comb begin
        q_x      = {1'b0, q};
        sum_x    = q_x + STEP_X;
        diff_x   = q_x - STEP_X;
        up_over  = q_x > LIM_UP_X;
        dn_under = q_x < STEP_X;
        counting = cke & ~clear & ~set & ~load;

        up_val = WIDTH'(sum_x);
        if (up_over) begin
            up_val = WRAP ? WIDTH'(sum_x - MAXP1_X) : MAX_V;
        end

        dn_val = WIDTH'(diff_x);
        if (dn_under) begin
            dn_val = WRAP ? WIDTH'(diff_x + MAXP1_X) : '0;
        end

        load_val = ({1'b0, d} > MAX_X) ? MAX_V : d;

        nxt = q;
        if (clear) begin
            nxt = RST_V;
        end else if (set) begin
            nxt = SET_V;
        end else if (load) begin
            nxt = load_val;
        end else if (cke) begin
            nxt = rew ? dn_val : up_val;
        end
    end

    assign q_next = nxt;
    assign z      = (nxt == '0);
    // Saturated hold at a limit still counts as a terminal event.
    assign tc     = counting & (rew ? dn_under : up_over);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_next[gi] = nxt[gi] ^ nxt[gi+1];
        end
    endgenerate
    assign gray_next[WIDTH-1] = nxt[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= RST_V;
            q_gray <= RST_G;
            zq     <= (RST_V == '0);
        end else begin
            q      <= nxt;
            q_gray <= gray_next;
            zq     <= (nxt == '0);
        end
    end

endmodule

// File: tb/tb_vcnt_gen.sv
// Directed bench for vcnt_gen: a wrapping 0..9 counter and a saturating
// step-3 counter, covering priority, clamp, hold and async reset.
module tb_vcnt_gen;

    logic       clk;
    logic       rst;

    logic       cke_a, clear_a, set_a, load_a, rew_a;
    logic [3:0] d_a, q_a, qn_a, qg_a;
    logic       z_a, zq_a, tc_a;

    logic       cke_b, clear_b, set_b, load_b, rew_b;
    logic [3:0] d_b, q_b, qn_b, qg_b;
    logic       z_b, zq_b, tc_b;

    int checks = 0;
    int errors = 0;

    int up_q  [5] = '{0, 3, 6, 9, 9};
    int up_tc [5] = '{0, 0, 0, 1, 1};
    int up_qn [5] = '{3, 6, 9, 9, 9};
    int dn_q  [5] = '{9, 6, 3, 0, 0};
    int dn_tc [5] = '{0, 0, 0, 1, 1};
    int dn_qn [5] = '{6, 3, 0, 0, 0};

    vcnt_gen #(.WIDTH(4), .MAX(9), .STEP(1), .WRAP(1)) dut_a (
        .clk(clk), .rst(rst), .cke(cke_a), .clear(clear_a), .set(set_a),
        .load(load_a), .d(d_a), .rew(rew_a), .q(q_a), .q_next(qn_a),
        .q_gray(qg_a), .z(z_a), .zq(zq_a), .tc(tc_a)
    );

    vcnt_gen #(.WIDTH(4), .MAX(9), .STEP(3), .WRAP(0)) dut_b (
        .clk(clk), .rst(rst), .cke(cke_b), .clear(clear_b), .set(set_b),
        .load(load_b), .d(d_b), .rew(rew_b), .q(q_b), .q_next(qn_b),
        .q_gray(qg_b), .z(z_b), .zq(zq_b), .tc(tc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray(input logic [3:0] x);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int v;
        rst = 1'b1;
        cke_a = 0; clear_a = 0; set_a = 0; load_a = 0; rew_a = 0; d_a = 0;
        cke_b = 0; clear_b = 0; set_b = 0; load_b = 0; rew_b = 0; d_b = 0;

        #7;
        chk("rst_q_a", q_a, 0);
        chk("rst_gray_a", qg_a, 0);
        chk("rst_zq_a", zq_a, 1);
        chk("rst_q_b", q_b, 0);
        tick();
        rst = 1'b0;

        // Wrapping up count 0..9,0
        cke_a = 1; rew_a = 0;
        #1;
        for (int i = 0; i <= 10; i++) begin
            v = i % 10;
            $display("up_a   step %0d q=%0d tc=%0b z=%0b", i, q_a, tc_a, z_a);
            chk("up_q", q_a, v);
            chk("up_gray", qg_a, gray(v[3:0]));
            chk("up_zq", zq_a, v == 0);
            chk("up_tc", tc_a, v == 9);
            chk("up_z", z_a, v == 9);
            chk("up_qn", qn_a, (v + 1) % 10);
            if (i < 10) tick();
        end

        // Wrapping down count 0,9,8,...,0
        rew_a = 1;
        #1;
        v = 0;
        for (int k = 0; k <= 10; k++) begin
            $display("dn_a   step %0d q=%0d tc=%0b", k, q_a, tc_a);
            chk("dn_q", q_a, v);
            chk("dn_gray", qg_a, gray(v[3:0]));
            chk("dn_tc", tc_a, v == 0);
            chk("dn_qn", qn_a, (v == 0) ? 9 : v - 1);
            if (k < 10) tick();
            v = (v == 0) ? 9 : v - 1;
        end

        // Load, then priority among clear/set/load
        rew_a = 0; load_a = 1; d_a = 5;
        #1;
        chk("load5_tc", tc_a, 0);
        chk("load5_qn", qn_a, 5);
        tick();
        load_a = 0;
        $display("load_a d=5 q=%0d", q_a);
        chk("load5_q", q_a, 5);

        clear_a = 1; set_a = 1; load_a = 1; d_a = 7;
        #1;
        chk("csl_tc", tc_a, 0);
        chk("csl_qn", qn_a, 0);
        chk("csl_z", z_a, 1);
        tick();
        $display("clear+set+load q=%0d", q_a);
        chk("csl_q", q_a, 0);
        chk("csl_zq", zq_a, 1);

        clear_a = 0;
        #1;
        chk("sl_tc", tc_a, 0);
        chk("sl_qn", qn_a, 9);
        tick();
        $display("set+load q=%0d", q_a);
        chk("sl_q", q_a, 9);

        set_a = 0; load_a = 0; clear_a = 1;
        tick();
        $display("clear q=%0d", q_a);
        chk("clr_q", q_a, 0);

        clear_a = 0; load_a = 1; d_a = 15;
        #1;
        chk("clamp_tc", tc_a, 0);
        chk("clamp_qn", qn_a, 9);
        tick();
        load_a = 0;
        $display("load d=15 q=%0d", q_a);
        chk("clamp_q", q_a, 9);

        // Hold with cke=0 while rew toggles
        cke_a = 0;
        for (int h = 0; h < 3; h++) begin
            rew_a = ~rew_a;
            #1;
            chk("hold_tc", tc_a, 0);
            chk("hold_qn", qn_a, 9);
            tick();
            $display("hold   step %0d rew=%0b q=%0d", h, rew_a, q_a);
            chk("hold_q", q_a, 9);
        end

        load_a = 1; d_a = 4;
        tick();
        load_a = 0;
        $display("load cke=0 d=4 q=%0d", q_a);
        chk("load4_q", q_a, 4);

        // Async reset between edges discards a pending load
        cke_a = 1; rew_a = 0;
        tick();
        chk("pre_rst_q5", q_a, 5);
        tick();
        chk("pre_rst_q6", q_a, 6);
        load_a = 1; d_a = 7;
        #3 rst = 1'b1;
        #1;
        $display("async rst q=%0d", q_a);
        chk("arst_q", q_a, 0);
        chk("arst_gray", qg_a, 0);
        chk("arst_zq", zq_a, 1);
        load_a = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_q", q_a, 0);
        tick();
        chk("resume_q1", q_a, 1);
        tick();
        $display("resume q=%0d", q_a);
        chk("resume_q2", q_a, 2);
        cke_a = 0;

        // Saturating step-3 counter up then down
        cke_b = 1; rew_b = 0;
        #1;
        for (int i = 0; i < 5; i++) begin
            $display("sat_up step %0d q=%0d tc=%0b", i, q_b, tc_b);
            chk("sat_up_q", q_b, up_q[i]);
            chk("sat_up_tc", tc_b, up_tc[i]);
            chk("sat_up_qn", qn_b, up_qn[i]);
            chk("sat_up_gray", qg_b, gray(4'(up_q[i])));
            if (i < 4) tick();
        end
        cke_b = 0;
        #1;
        chk("sat_idle_tc", tc_b, 0);
        chk("sat_idle_qn", qn_b, 9);

        cke_b = 1; rew_b = 1;
        #1;
        for (int i = 0; i < 5; i++) begin
            $display("sat_dn step %0d q=%0d tc=%0b", i, q_b, tc_b);
            chk("sat_dn_q", q_b, dn_q[i]);
            chk("sat_dn_tc", tc_b, dn_tc[i]);
            chk("sat_dn_qn", qn_b, dn_qn[i]);
            chk("sat_dn_z", z_b, dn_qn[i] == 0);
            if (i < 4) tick();
        end
        chk("sat_dn_zq", zq_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
